// File: rtl/cis_pkg.sv
// cis_pkg: shared state encoding and widths for the CIS line sequencer
package cis_pkg;
    localparam int PERIOD_W = 16;
    localparam int ADDR_W = 12;
    typedef enum logic [1:0] {IDLE, SP, PIX, TAIL} state_e;
endpackage

// File: rtl/cis_pix_timer.sv
// cis_pix_timer: pixel phase/index counters producing adc_cds, cis_wren and pix_addr
module cis_pix_timer
    import cis_pkg::*;
#(
    parameter int PIX_DIV = 4,
    parameter int DUMMY_PIX = 16,
    parameter int ACTIVE_PIX = 2592
) (
    input  logic              adc_clk,
    input  logic              reset,
    input  logic              pix_en_d,
    input  logic              pix_first_d,
    output logic              adc_cds,
    output logic              cis_wren,
    output logic [ADDR_W-1:0] pix_addr
);
    localparam int PH_W = $clog2(PIX_DIV);
    localparam int PIDX_W = $clog2(DUMMY_PIX + ACTIVE_PIX + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIX_DIV - 1);
    localparam logic [PH_W-1:0] HALF = PH_W'(PIX_DIV / 2);
    localparam logic [PIDX_W-1:0] DUMMY_L = PIDX_W'(DUMMY_PIX);
    logic [PH_W-1:0] ph_q, ph_d;
    logic [PIDX_W-1:0] pidx_q, pidx_d;
    logic adc_cds_q, adc_cds_d, cis_wren_q, cis_wren_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic wrap;
    always_comb begin
        wrap = ph_q == PH_LAST;
        ph_d = pix_first_d ? '0 : !pix_en_d ? ph_q : wrap ? '0 : ph_q + 1'b1;
        pidx_d = pix_first_d ? '0 : (pix_en_d && wrap) ? pidx_q + 1'b1 : pidx_q;
        adc_cds_d = pix_en_d && ph_d < HALF;
        cis_wren_d = pix_en_d && ph_d == PH_LAST && pidx_d >= DUMMY_L;
        pix_addr_d = cis_wren_d ? ADDR_W'(pidx_d - DUMMY_L) : pix_addr_q;
    end
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            ph_q <= '0;
            pidx_q <= '0;
            adc_cds_q <= 1'b0;
            cis_wren_q <= 1'b0;
            pix_addr_q <= '0;
        end else begin
            ph_q <= ph_d;
            pidx_q <= pidx_d;
            adc_cds_q <= adc_cds_d;
            cis_wren_q <= cis_wren_d;
            pix_addr_q <= pix_addr_d;
        end
    end
    assign adc_cds = adc_cds_q;
    assign cis_wren = cis_wren_q;
    assign pix_addr = pix_addr_q;
endmodule

// File: rtl/cis_line_seq.sv
// cis_line_seq: CIS line-scan timing sequencer; CIS_LINE_LIMIT_EN adds line_limit/scan_done
module cis_line_seq
    import cis_pkg::*;
#(
    parameter int SP_WIDTH = 4,
    parameter int PIX_DIV = 4,
    parameter int DUMMY_PIX = 16,
    parameter int ACTIVE_PIX = 2592
) (
    input  logic                adc_clk,
    input  logic                reset,
    input  logic                init_done,
    input  logic                start_cis,
    input  logic [PERIOD_W-1:0] sp_para,
`ifdef CIS_LINE_LIMIT_EN
    input  logic [15:0]         line_limit,
    output logic                scan_done,
`endif
    output logic                cis_sp,
    output logic                adc_cds,
    output logic                cis_wren,
    output logic [ADDR_W-1:0]   pix_addr,
    output logic                line_end,
    output logic                busy,
    output logic                period_err
);
    localparam logic [PERIOD_W-1:0] SP_L = PERIOD_W'(SP_WIDTH);
    localparam logic [PERIOD_W-1:0] PIX_END = PERIOD_W'(SP_WIDTH + (DUMMY_PIX + ACTIVE_PIX) * PIX_DIV);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(SP_WIDTH + (DUMMY_PIX + ACTIVE_PIX) * PIX_DIV + 1);
    state_e state_q, state_d;
    logic [PERIOD_W-1:0] lc_q, lc_d, p_q, p_d;
    logic period_err_q, period_err_d, cis_sp_q, cis_sp_d;
    logic line_end_q, line_end_d, busy_q, busy_d;
    logic start_ok, last, go, short_p, pix_en_d, pix_first_d, scan_done_d;
    assign last = state_q == TAIL && lc_q == p_q - 1'b1;
`ifdef CIS_LINE_LIMIT_EN
    logic [15:0] lim_q, lim_d, lines_q, lines_d;
    logic armed_q, armed_d, scan_done_q;
    always_comb begin
        start_ok = start_cis & init_done & armed_q;
        scan_done_d = last && lim_q != '0 && lines_q == lim_q - 1'b1;
        lim_d = state_q == IDLE ? line_limit : lim_q;
        lines_d = state_q == IDLE ? '0 : last ? lines_q + 1'b1 : lines_q;
        armed_d = !start_cis ? 1'b1 : scan_done_d ? 1'b0 : armed_q;
    end
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            lim_q <= '0;
            lines_q <= '0;
            armed_q <= 1'b1;
            scan_done_q <= 1'b0;
        end else begin
            lim_q <= lim_d;
            lines_q <= lines_d;
            armed_q <= armed_d;
            scan_done_q <= scan_done_d;
        end
    end
    assign scan_done = scan_done_q;
`else
    assign start_ok = start_cis & init_done;
    assign scan_done_d = 1'b0;
`endif
    always_comb begin
        go = start_ok && !scan_done_d && (state_q == IDLE || last);
        short_p = sp_para < MIN_PERIOD;
        p_d = go ? (short_p ? MIN_PERIOD : sp_para) : p_q;
        period_err_d = period_err_q | (go & short_p);
        lc_d = (state_q == IDLE || last) ? '0 : lc_q + 1'b1;
        state_d = ((state_q == IDLE || last) && !go) ? IDLE :
                  lc_d < SP_L ? SP : lc_d < PIX_END ? PIX : TAIL;
        cis_sp_d = state_d == SP;
        busy_d = state_d != IDLE;
        line_end_d = state_d == TAIL && lc_d == p_d - 1'b1;
        pix_en_d = state_d == PIX;
        pix_first_d = pix_en_d && lc_d == SP_L;
    end
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q <= IDLE;
            lc_q <= '0;
            p_q <= '0;
            period_err_q <= 1'b0;
            cis_sp_q <= 1'b0;
            line_end_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q <= lc_d;
            p_q <= p_d;
            period_err_q <= period_err_d;
            cis_sp_q <= cis_sp_d;
            line_end_q <= line_end_d;
            busy_q <= busy_d;
        end
    end
    cis_pix_timer #(
        .PIX_DIV(PIX_DIV),
        .DUMMY_PIX(DUMMY_PIX),
        .ACTIVE_PIX(ACTIVE_PIX)
    ) u_pix (
        .adc_clk(adc_clk),
        .reset(reset),
        .pix_en_d(pix_en_d),
        .pix_first_d(pix_first_d),
        .adc_cds(adc_cds),
        .cis_wren(cis_wren),
        .pix_addr(pix_addr)
    );
    assign cis_sp = cis_sp_q;
    assign line_end = line_end_q;
    assign busy = busy_q;
    assign period_err = period_err_q;
endmodule
